// File: rtl/mem_stage.sv
// Memory stage: EX/MEM and MEM/WB pipeline registers plus the
// request/wait/timeout controller for a single-port data memory.
module mem_stage #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             RegWrite_E,
  input  logic             MemtoReg_E,
  input  logic             MemWrite_E,
  input  logic             MemRead_E,
  input  logic [WIDTH-1:0] ALUOut_E,
  input  logic [WIDTH-1:0] WriteData_E,
  input  logic [4:0]       WriteReg_E,
  input  logic             ErrClr,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [WIDTH-1:0] ALUOut_M,
  output logic [4:0]       WriteReg_M,
  output logic             RegWrite_M,
  output logic             Stall_M,
  output logic [WIDTH-1:0] Result_W,
  output logic [4:0]       WriteReg_W,
  output logic             RegWrite_W,
  output logic             Misalign_M,
  output logic             BusErr
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ERR
  } state_t;

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic             rw_m_q, mtr_m_q;
  logic             mw_m_q, mr_m_q;
  logic [WIDTH-1:0] alu_m_q, wd_m_q;
  logic [4:0]       wr_m_q;

  logic             rw_w_q, mtr_w_q;
  logic [WIDTH-1:0] alu_w_q, rd_w_q;
  logic [4:0]       wr_w_q;

  logic memop, aligned, in_err, kill;

  assign memop   = mr_m_q | mw_m_q;
  assign aligned = (alu_m_q[1:0] == 2'b00);
  assign in_err  = (state_q == ERR);
  // Clearing an error retires the faulting op as a bubble.
  assign kill    = in_err & ErrClr;

  assign mem_req    = memop & aligned & ~in_err;
  assign mem_we     = mw_m_q;
  assign mem_addr   = alu_m_q;
  assign mem_wdata  = wd_m_q;
  assign Stall_M    = (mem_req & ~mem_ack) | in_err;
  assign Misalign_M = memop & ~aligned;
  assign BusErr     = in_err;

  assign ALUOut_M   = alu_m_q;
  assign WriteReg_M = wr_m_q;
  assign RegWrite_M = rw_m_q;

  assign Result_W   = mtr_w_q ? rd_w_q : alu_w_q;
  assign WriteReg_W = wr_w_q;
  assign RegWrite_W = rw_w_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_m_q  <= 1'b0;
      mtr_m_q <= 1'b0;
      mw_m_q  <= 1'b0;
      mr_m_q  <= 1'b0;
      alu_m_q <= '0;
      wd_m_q  <= '0;
      wr_m_q  <= '0;
    end else if (kill) begin
      rw_m_q  <= 1'b0;
      mtr_m_q <= 1'b0;
      mw_m_q  <= 1'b0;
      mr_m_q  <= 1'b0;
    end else if (!Stall_M) begin
      rw_m_q  <= RegWrite_E;
      mtr_m_q <= MemtoReg_E;
      mw_m_q  <= MemWrite_E;
      mr_m_q  <= MemRead_E;
      alu_m_q <= ALUOut_E;
      wd_m_q  <= WriteData_E;
      wr_m_q  <= WriteReg_E;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_w_q  <= 1'b0;
      mtr_w_q <= 1'b0;
      alu_w_q <= '0;
      rd_w_q  <= '0;
      wr_w_q  <= '0;
    end else if (Stall_M) begin
      rw_w_q <= 1'b0;
    end else begin
      // Stores and misaligned ops never write the register file.
      rw_w_q  <= rw_m_q & ~mw_m_q & ~Misalign_M;
      mtr_w_q <= mtr_m_q;
      alu_w_q <= alu_m_q;
      wr_w_q  <= wr_m_q;
      if (mem_req & mem_ack) begin
        rd_w_q <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (mem_req & ~mem_ack) begin
          state_d = WAIT;
          cnt_d   = 8'd1;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ERR: begin
        if (ErrClr) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule
